// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle HI/LO unit for MULT, MULTU, DIV, DIVU plus MTHI/MTLO.
// Signed operations run on operand magnitudes, and the result signs are applied in FIX.
// Optional macro MULT_DIV_FAST_MULT_EN: multiplies use a combinational product
// and skip the iterative phase. Divide timing does not change.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             Start,
  input  logic [3:0]       AluControl,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic             MtHi,
  input  logic             MtLo,
  input  logic [WIDTH-1:0] WrData,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_acc_hi;   // product high half / partial remainder
  logic [WIDTH-1:0]     r_acc_lo;   // multiplier then product low half / dividend then quotient
  logic [WIDTH-1:0]     r_opnd;     // multiplicand magnitude or divisor magnitude
  logic                 r_is_mult;
  logic                 r_neg_q;    // negate product/quotient in FIX
  logic                 r_neg_r;    // negate remainder in FIX
  logic                 r_div0;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_launch;
  logic                 w_signed_op;
  logic                 w_mult_op;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [WIDTH:0]       w_add;
  logic [WIDTH-1:0]     w_mul_hi;
  logic [WIDTH-1:0]     w_mul_lo;
  logic [WIDTH:0]       w_shift;
  logic                 w_ge;
  logic [WIDTH-1:0]     w_diff;
  logic [WIDTH-1:0]     w_div_hi;
  logic [WIDTH-1:0]     w_div_lo;
  logic [2*WIDTH-1:0]   w_prod_fix;
  logic [WIDTH-1:0]     w_quo_fix;
  logic [WIDTH-1:0]     w_rem_fix;
`ifdef MULT_DIV_FAST_MULT_EN
  logic [2*WIDTH-1:0]   w_fast_prod;
`endif

  assign Hi   = r_hi;
  assign Lo   = r_lo;
  assign Busy = r_busy;
  assign Done = r_done;

  // Decode the launch request and form the operand magnitudes.
  always_comb begin
    w_launch    = (r_state == S_IDLE) && Start && (AluControl[3:2] == 2'b10);
    w_signed_op = ~AluControl[0];
    w_mult_op   = AluControl[1];
    w_mag_a     = (w_signed_op && OpA[WIDTH-1]) ? -OpA : OpA;
    w_mag_b     = (w_signed_op && OpB[WIDTH-1]) ? -OpB : OpB;
  end

`ifdef MULT_DIV_FAST_MULT_EN
  assign w_fast_prod = {{WIDTH{1'b0}}, w_mag_a} * {{WIDTH{1'b0}}, w_mag_b};
`endif

  // Shift-add multiply step. The carry out of the add shifts into the accumulator.
  always_comb begin
    w_add    = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);
    w_mul_hi = w_add[WIDTH:1];
    w_mul_lo = {w_add[0], r_acc_lo[WIDTH-1:1]};
  end

  // Restoring divide step. The dividend MSB shifts out of acc_lo into the remainder.
  always_comb begin
    w_shift  = {r_acc_hi, r_acc_lo[WIDTH-1]};
    w_ge     = (w_shift >= {1'b0, r_opnd});
    w_diff   = w_shift[WIDTH-1:0] - r_opnd;
    w_div_hi = w_ge ? w_diff : w_shift[WIDTH-1:0];
    w_div_lo = {r_acc_lo[WIDTH-2:0], w_ge};
  end

  // Apply the recorded result signs to the unsigned core results.
  always_comb begin
    w_prod_fix = r_neg_q ? -{r_acc_hi, r_acc_lo} : {r_acc_hi, r_acc_lo};
    w_quo_fix  = r_neg_q ? -r_acc_lo : r_acc_lo;
    w_rem_fix  = r_neg_r ? -r_acc_hi : r_acc_hi;
  end

  // Control FSM, datapath registers and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_opnd    <= '0;
      r_is_mult <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_div0    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_is_mult <= w_mult_op;
            r_neg_q   <= w_signed_op & (OpA[WIDTH-1] ^ OpB[WIDTH-1]);
            r_neg_r   <= w_signed_op & OpA[WIDTH-1];
            r_div0    <= ~w_mult_op && (OpB == '0);
            r_cnt     <= CNT_W'(WIDTH - 1);
            r_busy    <= 1'b1;
            r_acc_hi  <= '0;
            r_state   <= S_ITER;
            if (w_mult_op) begin
              r_opnd   <= w_mag_a;
              r_acc_lo <= w_mag_b;
            end else begin
              r_opnd   <= w_mag_b;
              r_acc_lo <= w_mag_a;
            end
`ifdef MULT_DIV_FAST_MULT_EN
            if (w_mult_op) begin
              {r_acc_hi, r_acc_lo} <= w_fast_prod;
              r_state              <= S_FIX;
            end
`endif
          end else if (!Start) begin
            if (MtHi) r_hi <= WrData;
            if (MtLo) r_lo <= WrData;
          end
        end
        S_ITER: begin
          if (r_is_mult) begin
            r_acc_hi <= w_mul_hi;
            r_acc_lo <= w_mul_lo;
          end else begin
            r_acc_hi <= w_div_hi;
            r_acc_lo <= w_div_lo;
          end
          if (r_cnt == '0) begin
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_FIX: begin
          if (r_is_mult) begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end else begin
            // A zero divisor leaves the remainder equal to the original dividend.
            r_hi <= w_rem_fix;
            r_lo <= r_div0 ? '1 : w_quo_fix;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multicycle HI/LO unit for the MIPS core. It executes MULT, MULTU, DIV and DIVU, and handles HI/LO writes from MTHI and MTLO.
- Sits directly downstream of the ALU-control decode. It consumes AluControl codes 4'b1000–4'b1011 and the two register operands.
- It holds the architectural HI/LO registers read by MFHI/MFLO. The controller stalls on Busy and advances on Done.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- Start  input  1  launch request; sampled only in IDLE.
- AluControl  input  4  operation select: 1000 DIV, 1001 DIVU, 1010 MULT, 1011 MULTU.
- OpA  input  WIDTH  rs value (multiplicand / dividend).
- OpB  input  WIDTH  rt value (multiplier / divisor).
- MtHi  input  1  write WrData to HI.
- MtLo  input  1  write WrData to LO.
- WrData  input  WIDTH  rs value for MTHI/MTLO.
- Hi  output  WIDTH  HI register.
- Lo  output  WIDTH  LO register.
- Busy  output  1  operation in flight.
- Done  output  1  one-cycle pulse; Hi/Lo hold the new result during this cycle.

Behaviour:
- Reset: reset_n low at an edge gives state IDLE, Hi=0, Lo=0, Busy=0, Done=0, counter=0. This overrides any in-flight operation, which is discarded.
- States: IDLE, ITER, FIX.
- IDLE, launch:
  - Start=1 with AluControl in 1000–1011 latches OpA, OpB, op code and signedness. Later changes to OpA/OpB are ignored.
  - For signed ops the magnitudes of OpA and OpB are latched. Result signs are recorded: quotient/product sign = OpA[31]^OpB[31]; remainder sign = OpA[31].
  - Counter loads WIDTH-1, state goes to ITER.
- IDLE, other Start cases: Start with any other AluControl value is ignored; no Busy, no Done.
- ITER: one bit per cycle, 32 cycles total; counter decrements each cycle. Leaves to FIX when counter==0.
  - Multiply: shift-add into a 64-bit accumulator {P_hi, P_lo}.
  - Divide: restoring division. Remainder is shifted left by 1 with the next dividend bit. Subtract divisor when remainder >= divisor and set the quotient bit.
- FIX (one cycle):
  - Apply two's-complement negation per the recorded signs (signed ops only).
  - Multiply writes Hi=product[63:32], Lo=product[31:0].
  - Divide writes Lo=quotient, Hi=remainder.
  - Done=1 for exactly this one following cycle; return to IDLE.
- Busy=1 for the whole operation, i.e. in ITER and FIX. It is registered, so it is high from the cycle after the Start edge until Done rises. Busy and Done are never high together.
- Latency: Start sampled at edge E0; Done high in the cycle after edge E33 (34 cycles).
- Divide by zero (OpB==0): operation runs full latency and never stalls or hangs. Result is Hi=OpA (original, unsigned/signed as given) and Lo=32'hFFFFFFFF for both DIV and DIVU.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000, Hi=0.
- MtHi/MtLo: honoured only in IDLE with Start=0. Each writes its register at that edge; both may write together. They are ignored while Busy.
- Start and MtHi/MtLo together in IDLE: Start wins, Mt writes are dropped.
- Start while Busy: ignored; no queueing.
- Hi/Lo change only on a FIX edge, an Mt write, or reset.

Optional Feature:
- Macro: MULT_DIV_FAST_MULT_EN.
- Defined: MULT/MULTU skip ITER. The start edge goes straight to FIX using a combinational 64-bit signed/unsigned product, so Done is high in the cycle after E1 (2-cycle latency). Divide timing is unchanged.
- Undefined: multiply uses the 34-cycle iterative path; no hardware multiplier is inferred.

Test Plan:
- Reset mid-DIVU (assert reset_n=0 at cycle 10) -> Hi=0, Lo=0, Busy=0, Done=0 next cycle; a later Start behaves normally.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001. Done one cycle, 34 cycles after Start (2 with MULT_DIV_FAST_MULT_EN).
- MULT -7*3 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; DIV -7/2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- DIVU 100/0 -> Hi=100, Lo=0xFFFFFFFF after 34 cycles. DIV 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- MtHi=1, WrData=0x1234 in IDLE -> Hi=0x1234 next cycle. MtLo during Busy -> Lo unchanged. Start+MtLo same cycle -> Lo only updated by the result.
- Start with AluControl=0010 -> Busy stays 0, no Done. Second Start during Busy -> exactly one Done, first operation's result.
